// File: rtl/vscale_store_buffer.sv
// In-order store buffer between WB and the data-memory port.
// Provides byte-lane store-to-load forwarding and a fence drain.
module vscale_store_buffer #(
    parameter int unsigned XPR_LEN = 32,
    parameter int unsigned DEPTH   = 4,
    parameter bit          FWD_EN  = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      st_valid,
    output logic                      st_ready,
    input  logic [XPR_LEN-1:0]        st_addr,
    input  logic [XPR_LEN-1:0]        st_data,
    input  logic [1:0]                st_size,
    output logic                      st_err,
    input  logic [XPR_LEN-1:0]        ld_addr,
    input  logic [1:0]                ld_size,
    output logic                      ld_hit,
    output logic                      ld_conflict,
    output logic [XPR_LEN-1:0]        ld_fwd_data,
    input  logic                      fence_req,
    output logic                      fence_done,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [XPR_LEN-1:0]        mem_addr,
    output logic [XPR_LEN-1:0]        mem_wdata,
    output logic [3:0]                mem_wstrb,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TAG_W = XPR_LEN - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]   tag_q  [DEPTH];
    logic [XPR_LEN-1:0] data_q [DEPTH];
    logic [3:0]         strb_q [DEPTH];

    logic [PTR_W-1:0] head_q, tail_q;
    logic             full, empty, push, pop, accept;
    logic             st_misalign, fence_done_d;
    logic [3:0]       st_mask, ld_mask;
    logic [XPR_LEN-1:0] st_wdata;

    logic               y_found;
    logic [3:0]         y_strb;
    logic [XPR_LEN-1:0] y_data;
    logic [PTR_W-1:0]   fwd_idx;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign st_ready = ~full & (state_q == IDLE);
    assign accept   = st_valid & st_ready;
    assign push     = accept & ~st_misalign;
    assign mem_valid = ~empty;
    assign pop      = mem_valid & mem_ready;

    // Store formatting: lane replication and strobe generation
    always_comb begin
        st_mask     = lane_mask(st_size, st_addr[1:0]);
        st_misalign = 1'b0;
        st_wdata    = st_data;
        case (st_size)
            2'd0: st_wdata = XPR_LEN'({4{st_data[7:0]}});
            2'd1: begin
                st_wdata    = XPR_LEN'({2{st_data[15:0]}});
                st_misalign = st_addr[0];
            end
            default: st_misalign = (st_addr[1:0] != 2'b00);
        endcase
    end

    assign mem_addr  = {tag_q[head_q], 2'b00};
    assign mem_wdata = data_q[head_q];
    assign mem_wstrb = strb_q[head_q];

    // Entry payload; validity is tracked by head/count, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[tail_q]  <= st_addr[XPR_LEN-1:2];
            data_q[tail_q] <= st_wdata;
            strb_q[tail_q] <= st_mask;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count      <= '0;
            st_err     <= 1'b0;
            fence_done <= 1'b0;
            state_q    <= IDLE;
        end else begin
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_q + PTR_W'(1);
            count      <= count + CNT_W'(push) - CNT_W'(pop);
            st_err     <= accept & st_misalign;
            fence_done <= fence_done_d;
            state_q    <= state_d;
        end
    end

    // Fence FSM; fence_done rises together with entry into DONE
    always_comb begin
        state_d      = state_q;
        fence_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (fence_req) begin
                    if (empty) fence_done_d = 1'b1;
                    else       state_d      = DRAIN;
                end
            end
            DRAIN: begin
                if (empty || (pop && count == CNT_W'(1))) begin
                    state_d      = DONE;
                    fence_done_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Oldest-to-youngest scan; the last match wins so Y is the youngest
    always_comb begin
        ld_mask = lane_mask(ld_size, ld_addr[1:0]);
        y_found = 1'b0;
        y_strb  = '0;
        y_data  = '0;
        fwd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count) && (tag_q[fwd_idx] == ld_addr[XPR_LEN-1:2]) &&
                ((strb_q[fwd_idx] & ld_mask) != 4'b0000)) begin
                y_found = 1'b1;
                y_strb  = strb_q[fwd_idx];
                y_data  = data_q[fwd_idx];
            end
        end
        ld_hit      = y_found & FWD_EN & ((y_strb & ld_mask) == ld_mask);
        ld_conflict = y_found & ~ld_hit;
        ld_fwd_data = ld_hit ? y_data : '0;
    end

endmodule

// File: tb/tb_vscale_store_buffer.sv
// Directed + randomized bench for vscale_store_buffer against a queue-based reference model.
module tb_vscale_store_buffer;

    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, st_valid, st_ready, st_err, ld_hit, ld_conflict;
    logic        fence_req, fence_done, mem_valid, mem_ready;
    logic [31:0] st_addr, st_data, ld_addr, ld_fwd_data, mem_addr, mem_wdata;
    logic [1:0]  st_size, ld_size;
    logic [3:0]  mem_wstrb;
    logic [2:0]  count;

    logic        z_st_valid, z_st_ready, z_st_err, z_ld_hit, z_ld_conflict, z_fence_done, z_mem_valid;
    logic [31:0] z_st_addr, z_st_data, z_ld_addr, z_ld_fwd_data, z_mem_addr, z_mem_wdata;
    logic [1:0]  z_st_size, z_ld_size;
    logic [3:0]  z_mem_wstrb;
    logic [2:0]  z_count;

    vscale_store_buffer #(.XPR_LEN(32), .DEPTH(D), .FWD_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .st_err(st_err),
        .ld_addr(ld_addr), .ld_size(ld_size), .ld_hit(ld_hit), .ld_conflict(ld_conflict),
        .ld_fwd_data(ld_fwd_data), .fence_req(fence_req), .fence_done(fence_done),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .count(count));

    vscale_store_buffer #(.XPR_LEN(32), .DEPTH(D), .FWD_EN(1'b0)) dut_nofwd (
        .clk(clk), .reset_n(reset_n), .st_valid(z_st_valid), .st_ready(z_st_ready),
        .st_addr(z_st_addr), .st_data(z_st_data), .st_size(z_st_size), .st_err(z_st_err),
        .ld_addr(z_ld_addr), .ld_size(z_ld_size), .ld_hit(z_ld_hit), .ld_conflict(z_ld_conflict),
        .ld_fwd_data(z_ld_fwd_data), .fence_req(1'b0), .fence_done(z_fence_done),
        .mem_valid(z_mem_valid), .mem_ready(1'b0), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_wstrb(z_mem_wstrb), .count(z_count));

    typedef struct packed {
        logic [29:0] tag;
        logic [31:0] data;
        logic [3:0]  strb;
    } ent_t;

    ent_t q[$];
    bit   fencing, post_drain, exp_done, exp_err;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] mask_of(input logic [1:0] sz, input logic [1:0] off);
        int nb = nbytes(sz);
        if (nb == 4) return 4'hf;
        return 4'(((1 << nb) - 1) << off);
    endfunction

    function automatic bit misaligned(input logic [1:0] sz, input logic [1:0] off);
        return (int'(off) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        int nb = nbytes(sz);
        for (int b = 0; b < 4; b++) r[8*b +: 8] = d[8*(b % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] base;
        case ($urandom % 3)
            0:       base = 32'h200;
            1:       base = 32'h204;
            default: base = 32'h300;
        endcase
        return base + 32'($urandom % 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output with the model, then advance one clock and update the model
    task automatic cycle();
        ent_t y, e;
        bit found, hit, rdy, pop, push, new_done;
        logic [3:0] lm;
        int sz;
        y = '0;
        #1;
        rdy = (q.size() < D) && !fencing && !post_drain;
        chk("st_ready", 32'(st_ready), 32'(rdy));
        chk("count", 32'(count), 32'(q.size()));
        chk("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
        chk("st_err", 32'(st_err), 32'(exp_err));
        chk("fence_done", 32'(fence_done), 32'(exp_done));
        if (q.size() != 0) begin
            chk("mem_addr", mem_addr, {q[0].tag, 2'b00});
            chk("mem_wdata", mem_wdata, q[0].data);
            chk("mem_wstrb", 32'(mem_wstrb), 32'(q[0].strb));
        end
        lm = mask_of(ld_size, ld_addr[1:0]);
        found = 1'b0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!found && q[i].tag == ld_addr[31:2] && (q[i].strb & lm) != 4'b0) begin
                found = 1'b1;
                y = q[i];
            end
        end
        hit = found && ((y.strb & lm) == lm);
        chk("ld_hit", 32'(ld_hit), 32'(hit));
        chk("ld_conflict", 32'(ld_conflict), 32'(found && !hit));
        chk("ld_fwd_data", ld_fwd_data, hit ? y.data : 32'h0);

        @(posedge clk);
        sz   = q.size();
        pop  = (sz != 0) && mem_ready;
        push = st_valid && rdy && !misaligned(st_size, st_addr[1:0]);
        exp_err  = st_valid && rdy && misaligned(st_size, st_addr[1:0]);
        new_done = 1'b0;
        if (post_drain) post_drain = 1'b0;
        else if (fencing) begin
            if (sz == 0 || (pop && sz == 1)) begin
                fencing = 1'b0; post_drain = 1'b1; new_done = 1'b1;
            end
        end else if (fence_req) begin
            if (sz == 0) new_done = 1'b1;
            else         fencing  = 1'b1;
        end
        exp_done = new_done;
        if (pop) void'(q.pop_front());
        if (push) begin
            e.tag  = st_addr[31:2];
            e.strb = mask_of(st_size, st_addr[1:0]);
            e.data = replicate(st_size, st_data);
            q.push_back(e);
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; st_valid = 1'b0; fence_req = 1'b0; mem_ready = 1'b1;
        ld_addr = 32'h200; ld_size = 2'd2;
        q.delete(); fencing = 1'b0; post_drain = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_mem_valid", 32'(mem_valid), 0);
        chk("rst_st_ready", 32'(st_ready), 1);
        chk("rst_st_err", 32'(st_err), 0);
        chk("rst_fence_done", 32'(fence_done), 0);
        chk("rst_ld_hit", 32'(ld_hit), 0);
        chk("rst_ld_conflict", 32'(ld_conflict), 0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_hold_mem_valid", 32'(mem_valid), 0);
            chk("rst_hold_count", 32'(count), 0);
        end
        reset_n = 1'b1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_valid = 1'b1; st_addr = a; st_data = d; st_size = s;
        cycle();
        st_valid = 1'b0;
    endtask

    initial begin
        int guard;
        st_addr = '0; st_data = '0; st_size = '0;
        z_st_valid = 1'b0; z_st_addr = '0; z_st_data = '0; z_st_size = '0;
        z_ld_addr = 32'h200; z_ld_size = 2'd2;
        do_reset();

        // No-forwarding instance: overlap always stalls
        z_st_valid = 1'b1; z_st_addr = 32'h200; z_st_data = 32'hCAFEF00D; z_st_size = 2'd2;
        mem_ready = 1'b0;
        cycle();
        z_st_valid = 1'b0;
        #1;
        chk("nofwd_count", 32'(z_count), 1);
        chk("nofwd_conflict", 32'(z_ld_conflict), 1);
        chk("nofwd_hit", 32'(z_ld_hit), 0);
        chk("nofwd_data", z_ld_fwd_data, 0);
        z_ld_addr = 32'h300; #1;
        chk("nofwd_miss_conflict", 32'(z_ld_conflict), 0);

        // Byte store formatting and misaligned drop
        put(32'h103, 32'h000000AB, 2'd0);
        chk("sb_addr", mem_addr, 32'h100);
        chk("sb_wstrb", 32'(mem_wstrb), 32'h8);
        chk("sb_wdata", mem_wdata, 32'hABABABAB);
        put(32'h102, 32'h12345678, 2'd2);
        chk("misalign_err", 32'(st_err), 1);
        chk("misalign_count", 32'(count), 1);
        cycle();
        chk("err_one_cycle", 32'(st_err), 0);
        mem_ready = 1'b1; cycle(); cycle(); mem_ready = 1'b0;

        // Fill to full, then push/pop with st_valid held
        for (int i = 0; i < 4; i++) put(32'h400 + 32'(4 * i), $urandom, 2'd2);
        chk("full_count", 32'(count), 4);
        chk("full_ready", 32'(st_ready), 0);
        st_valid = 1'b1; st_addr = 32'h500; st_data = 32'h5A5A5A5A; st_size = 2'd2;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        st_valid = 1'b0;
        chk("stream_count", 32'(count), 3);
        for (int i = 0; i < 4; i++) cycle();
        mem_ready = 1'b0;

        // Forwarding: full hit, partial conflict, miss
        put(32'h200, 32'h11223344, 2'd2);
        put(32'h201, 32'h000000EE, 2'd0);
        ld_addr = 32'h201; ld_size = 2'd0; #1;
        chk("lbu_hit", 32'(ld_hit), 1);
        chk("lbu_data", ld_fwd_data, 32'hEEEEEEEE);
        ld_addr = 32'h200; ld_size = 2'd2; #1;
        chk("lw_conflict", 32'(ld_conflict), 1);
        chk("lw_conflict_hit", 32'(ld_hit), 0);
        ld_addr = 32'h300; #1;
        chk("lw_miss_hit", 32'(ld_hit), 0);
        chk("lw_miss_conflict", 32'(ld_conflict), 0);
        cycle();

        // Fence over two entries with mem_ready on alternate cycles
        fence_req = 1'b1; cycle(); fence_req = 1'b0;
        st_valid = 1'b1; st_addr = 32'h600; st_size = 2'd2;
        guard = 0;
        while (!fence_done && guard < 20) begin
            mem_ready = guard[0];
            chk("drain_ready", 32'(st_ready), 0);
            cycle();
            guard++;
        end
        chk("fence_done_seen", 32'(fence_done), 1);
        chk("fence_count", 32'(count), 0);
        st_valid = 1'b0; mem_ready = 1'b0;
        cycle();
        fence_req = 1'b1; cycle(); fence_req = 1'b0;
        chk("fence_empty_done", 32'(fence_done), 1);
        cycle();
        chk("fence_empty_pulse", 32'(fence_done), 0);

        // Reset in the middle of a drain
        for (int i = 0; i < 3; i++) put(32'h700 + 32'(4 * i), $urandom, 2'd2);
        fence_req = 1'b1; mem_ready = 1'b1; cycle(); fence_req = 1'b0;
        cycle();
        do_reset();
        for (int i = 0; i < 3; i++) cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            st_valid  = ($urandom % 2) == 0;
            st_addr   = pick_addr();
            st_data   = $urandom;
            st_size   = 2'($urandom % 4);
            ld_addr   = pick_addr();
            ld_size   = 2'($urandom % 4);
            mem_ready = ($urandom % 3) != 0;
            fence_req = ($urandom % 25) == 0;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
